// File: rtl/life_grid_engine_if.sv
// Control, write-port and status bundle between the board logic and the Game-of-Life engine.
interface life_grid_engine_if #(
  parameter int NR       = 20,
  parameter int NC       = 20,
  parameter int ADDR_LEN = 6,
  parameter int GEN_W    = 16,
  parameter int POP_W    = $clog2(NR*NC+1)
);
  logic                run;
  logic                tick;
  logic                step;
  logic                load;
  logic [NR*NC-1:0]    preset;
  logic                wrap_en;
  logic [8:0]          birth_mask;
  logic [8:0]          survive_mask;
  logic                wr_en;
  logic [ADDR_LEN-1:0] wr_row;
  logic [ADDR_LEN-1:0] wr_col;
  logic                wr_data;
  logic [NR*NC-1:0]    states;
  logic [GEN_W-1:0]    generation;
  logic [POP_W-1:0]    population;
  logic                gen_done;
  logic                stable;
  logic                extinct;
  logic                halted;

  modport master (
    output run, tick, step, load, preset, wrap_en, birth_mask, survive_mask,
           wr_en, wr_row, wr_col, wr_data,
    input  states, generation, population, gen_done, stable, extinct, halted
  );

  modport slave (
    input  run, tick, step, load, preset, wrap_en, birth_mask, survive_mask,
           wr_en, wr_row, wr_col, wr_data,
    output states, generation, population, gen_done, stable, extinct, halted
  );
endinterface

// File: rtl/life_grid_engine.sv
// Game-of-Life cell array with programmable B/S rule, toroidal or dead edges,
// run/step control, generation/population counters and still-life halt.
module life_grid_engine #(
  parameter int NR       = 20,
  parameter int NC       = 20,
  parameter int ADDR_LEN = 6,
  parameter int GEN_W    = 16,
  parameter int POP_W    = $clog2(NR*NC+1)
) (
  input logic               clk,
  input logic               clr,
  life_grid_engine_if.slave bus
);
  localparam int N = NR*NC;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fsm_t;

  fsm_t             state_q, state_d;
  logic [N-1:0]     grid_q, grid_nxt, grid_wr;
  logic [GEN_W-1:0] gen_q;
  logic [POP_W-1:0] pop_q;
  logic             done_q, stable_q;
  logic             adv, do_adv, wr_hit, grid_same;
  logic [3:0]       nbr;

  function automatic logic in_grid(input int r, input int c);
    return (r >= 0) && (r < NR) && (c >= 0) && (c < NC);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [N-1:0] g);
    logic [POP_W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p = p + POP_W'(g[i]);
    return p;
  endfunction

  // Wrapped coordinates are always in range; the dead-edge case masks them off instead.
  always_comb begin
    grid_nxt = '0;
    nbr      = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              nbr = nbr + {3'b000, grid_q[((r+dr+NR)%NR)*NC + ((c+dc+NC)%NC)]
                                   & (bus.wrap_en | in_grid(r+dr, c+dc))};
          end
        end
        grid_nxt[r*NC+c] = grid_q[r*NC+c] ? bus.survive_mask[nbr] : bus.birth_mask[nbr];
      end
    end
  end

  assign grid_same = (grid_nxt == grid_q);

  always_comb begin
    grid_wr = grid_q;
    wr_hit  = ({1'b0, bus.wr_row} < (ADDR_LEN+1)'(NR)) &&
              ({1'b0, bus.wr_col} < (ADDR_LEN+1)'(NC));
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (bus.wr_row == ADDR_LEN'(r) && bus.wr_col == ADDR_LEN'(c))
          grid_wr[r*NC+c] = bus.wr_data;
  end

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        adv = bus.step;
        if (bus.run) state_d = RUN;
      end
      RUN: begin
        adv = bus.tick;
        if (!bus.run) state_d = IDLE;
        else if (bus.tick && !bus.load && !bus.wr_en && grid_same) state_d = HALT;
      end
      HALT: begin
        if (!bus.run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // load and write pre-empt an advance in the same cycle; the advance is simply lost
  assign do_adv = adv & ~bus.load & ~bus.wr_en;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      pop_q    <= '0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= popcount(grid_q);
      done_q  <= do_adv;
      if (bus.load) begin
        grid_q   <= bus.preset;
        gen_q    <= '0;
        stable_q <= 1'b0;
      end else if (bus.wr_en) begin
        if (wr_hit) begin
          grid_q   <= grid_wr;
          stable_q <= 1'b0;
        end
      end else if (adv) begin
        grid_q   <= grid_nxt;
        gen_q    <= gen_q + GEN_W'(1);
        stable_q <= grid_same;
      end
    end
  end

  assign bus.states     = grid_q;
  assign bus.generation = gen_q;
  assign bus.population = pop_q;
  assign bus.gen_done   = done_q;
  assign bus.stable     = stable_q;
  assign bus.extinct    = (pop_q == '0);
  assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine on an 8x8 grid: directed scenarios plus random rules and boards.
module tb_life_grid_engine;
  localparam int NR = 8;
  localparam int NC = 8;
  localparam int AL = 4;
  localparam int GW = 16;
  localparam int N  = NR*NC;
  localparam int PW = $clog2(N+1);
  localparam logic [8:0] B_CONWAY = 9'h008;
  localparam logic [8:0] S_CONWAY = 9'h00C;
  localparam logic [8:0] B_HIGH   = 9'h048;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  life_grid_engine_if #(.NR(NR), .NC(NC), .ADDR_LEN(AL), .GEN_W(GW), .POP_W(PW)) bus ();

  life_grid_engine #(.NR(NR), .NC(NC), .ADDR_LEN(AL), .GEN_W(GW), .POP_W(PW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    logic [N-1:0] grid;
    int           gen;
    logic         stb;
    logic         hlt;
    int           pop;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           passes = 0;
  bit           pop_pend = 1'b0;
  int           pop_exp = 0;
  logic [N-1:0] mgrid = '0;
  int           mgen = 0;
  logic         mhalt = 1'b0;
  logic [8:0]   mb = B_CONWAY;
  logic [8:0]   ms = S_CONWAY;
  logic         mwrap = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  // Reference: zero- or wrap-padded board, sum of the 3x3 window minus the centre.
  function automatic logic [N-1:0] life_ref(input logic [N-1:0] g, input logic [8:0] b,
                                            input logic [8:0] s, input logic w);
    int pad [NR+2][NC+2];
    logic [N-1:0] res;
    res = '0;
    for (int r = 0; r < NR+2; r++) begin
      for (int c = 0; c < NC+2; c++) begin
        int sr, sc;
        sr = r - 1;
        sc = c - 1;
        if (w) begin
          sr = (sr + NR) % NR;
          sc = (sc + NC) % NC;
        end
        pad[r][c] = (sr >= 0 && sr < NR && sc >= 0 && sc < NC) ? int'(g[sr*NC+sc]) : 0;
      end
    end
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        int sum;
        sum = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) sum += pad[r+i][c+j];
        sum -= pad[r+1][c+1];
        res[r*NC+c] = (pad[r+1][c+1] != 0) ? s[sum] : b[sum];
      end
    end
    return res;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_rule(input logic [8:0] b, input logic [8:0] s, input logic w);
    mb = b; ms = s; mwrap = w;
    bus.birth_mask = b; bus.survive_mask = s; bus.wrap_en = w;
  endtask

  task automatic push_adv(input logic in_run);
    exp_t e;
    e.grid = life_ref(mgrid, mb, ms, mwrap);
    e.gen  = (mgen + 1) % 65536;
    e.stb  = (e.grid == mgrid);
    e.hlt  = in_run & e.stb;
    e.pop  = $countones(e.grid);
    sb.push_back(e);
    mgrid = e.grid;
    mgen  = e.gen;
    mhalt = e.hlt;
  endtask

  task automatic do_step();
    push_adv(1'b0);
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
  endtask

  task automatic do_tick();
    push_adv(1'b1);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic load_grid(input logic [N-1:0] g);
    bus.preset = g;
    bus.load   = 1'b1;
    cyc();
    bus.load = 1'b0;
    mgrid = g;
    mgen  = 0;
  endtask

  task automatic write_cell(input int r, input int c, input logic d);
    bus.wr_row  = AL'(r);
    bus.wr_col  = AL'(c);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    if (r < NR && c < NC) mgrid[r*NC+c] = d;
  endtask

  // Monitor: each gen_done pops one expected advance; population is due one cycle later.
  always @(negedge clk) begin
    if (clr !== 1'b1) begin
      pop_pend = 1'b0;
    end else begin
      if (pop_pend) begin
        chk("population", 64'(bus.population), 64'(pop_exp));
        pop_pend = 1'b0;
      end
      if (bus.gen_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_gen_done", 64'(bus.gen_done), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("adv_states", 64'(bus.states), 64'(mon_e.grid));
          chk("adv_generation", 64'(bus.generation), 64'(mon_e.gen));
          chk("adv_stable", 64'(bus.stable), 64'(mon_e.stb));
          chk("adv_halted", 64'(bus.halted), 64'(mon_e.hlt));
          pop_pend = 1'b1;
          pop_exp  = mon_e.pop;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] horiz, vert, glider, hl, pv;
    int k;
    horiz  = '0; horiz[2*NC+1] = 1'b1; horiz[2*NC+2] = 1'b1; horiz[2*NC+3] = 1'b1;
    vert   = '0; vert[1*NC+2] = 1'b1;  vert[2*NC+2] = 1'b1;  vert[3*NC+2] = 1'b1;
    glider = '0; glider[0*NC+1] = 1'b1; glider[1*NC+2] = 1'b1;
    glider[2*NC+0] = 1'b1; glider[2*NC+1] = 1'b1; glider[2*NC+2] = 1'b1;
    hl = '0; hl[2*NC+2] = 1'b1; hl[2*NC+3] = 1'b1; hl[2*NC+4] = 1'b1;
    hl[4*NC+2] = 1'b1; hl[4*NC+3] = 1'b1; hl[4*NC+4] = 1'b1;

    bus.run = 1'b0; bus.tick = 1'b0; bus.step = 1'b0; bus.load = 1'b0; bus.preset = '0;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = 1'b0;
    set_rule(B_CONWAY, S_CONWAY, 1'b0);

    repeat (3) @(posedge clk);
    #3 clr = 1'b1;
    look();
    chk("rst_states", 64'(bus.states), 64'd0);
    chk("rst_generation", 64'(bus.generation), 64'd0);
    chk("rst_population", 64'(bus.population), 64'd0);
    chk("rst_gen_done", 64'(bus.gen_done), 64'd0);
    chk("rst_stable", 64'(bus.stable), 64'd0);
    chk("rst_extinct", 64'(bus.extinct), 64'd1);
    chk("rst_halted", 64'(bus.halted), 64'd0);

    // Blinker, dead edges
    write_cell(2, 1, 1'b1);
    write_cell(2, 2, 1'b1);
    write_cell(2, 3, 1'b1);
    write_cell(9, 2, 1'b1);
    look();
    chk("write_row", 64'(bus.states), 64'(horiz));
    do_step();
    look();
    chk("blinker_vertical", 64'(bus.states), 64'(vert));
    look();
    chk("gen_done_once", 64'(bus.gen_done), 64'd0);
    chk("blinker_not_extinct", 64'(bus.extinct), 64'd0);
    do_step();
    look();
    chk("blinker_restored", 64'(bus.states), 64'(horiz));

    // Glider on a torus returns home after 32 generations
    set_rule(B_CONWAY, S_CONWAY, 1'b1);
    load_grid(glider);
    look();
    chk("load_gen_zero", 64'(bus.generation), 64'd0);
    bus.run = 1'b1; bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    look();
    chk("entry_tick_ignored", 64'(bus.generation), 64'd0);
    for (int i = 0; i < 32; i++) begin
      do_tick();
      cyc();
    end
    look();
    chk("glider_home", 64'(bus.states), 64'(glider));
    chk("glider_gen32", 64'(bus.generation), 64'd32);
    bus.run = 1'b0;
    cyc();

    // Glider into a dead corner settles to a block and halts
    set_rule(B_CONWAY, S_CONWAY, 1'b0);
    load_grid(glider);
    bus.run = 1'b1;
    cyc();
    k = 0;
    mhalt = 1'b0;
    while (!mhalt && k < 100) begin
      do_tick();
      cyc();
      k++;
    end
    cyc();
    look();
    chk("corner_halted", 64'(bus.halted), 64'd1);
    chk("corner_stable", 64'(bus.stable), 64'd1);
    chk("corner_block_pop", 64'(bus.population), 64'd4);
    repeat (3) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
    end
    look();
    chk("halt_gen_frozen", 64'(bus.generation), 64'(mgen));
    bus.run = 1'b0;
    cyc();
    look();
    chk("halt_to_idle", 64'(bus.halted), 64'd0);

    // HighLife births on six neighbours, Conway does not
    set_rule(B_HIGH, S_CONWAY, 1'b0);
    load_grid(hl);
    do_step();
    look();
    chk("highlife_birth", 64'(bus.states[3*NC+3]), 64'd1);
    set_rule(B_CONWAY, S_CONWAY, 1'b0);
    load_grid(hl);
    do_step();
    look();
    chk("conway_no_birth", 64'(bus.states[3*NC+3]), 64'd0);

    // load > wr_en > step in one cycle
    pv = {$urandom(), $urandom()};
    bus.preset = pv; bus.load = 1'b1;
    bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = ~pv[0]; bus.wr_en = 1'b1;
    bus.step = 1'b1;
    cyc();
    bus.load = 1'b0; bus.wr_en = 1'b0; bus.step = 1'b0;
    mgrid = pv; mgen = 0;
    look();
    chk("prio_states", 64'(bus.states), 64'(pv));
    chk("prio_generation", 64'(bus.generation), 64'd0);
    chk("prio_no_done", 64'(bus.gen_done), 64'd0);
    bus.run = 1'b1;
    cyc();
    bus.tick = 1'b1;
    write_cell(5, 5, ~mgrid[5*NC+5]);
    bus.tick = 1'b0;
    look();
    chk("wr_tick_states", 64'(bus.states), 64'(mgrid));
    chk("wr_tick_no_done", 64'(bus.gen_done), 64'd0);
    chk("wr_tick_generation", 64'(bus.generation), 64'd0);
    bus.run = 1'b0;
    cyc();

    // Random rules, boards and writes, stepped from IDLE
    for (int it = 0; it < 12; it++) begin
      set_rule(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      load_grid({$urandom(), $urandom()});
      if (it % 3 == 0) write_cell($urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      repeat (3) do_step();
      cyc();
    end

    // Asynchronous clear between edges
    set_rule(B_CONWAY, S_CONWAY, 1'b1);
    load_grid(glider);
    bus.run = 1'b1;
    cyc();
    repeat (3) begin
      do_tick();
      cyc();
    end
    repeat (3) cyc();
    @(posedge clk);
    #3;
    bus.run = 1'b0;
    clr = 1'b0;
    #1;
    chk("async_clr_states", 64'(bus.states), 64'd0);
    chk("async_clr_extinct", 64'(bus.extinct), 64'd1);
    chk("async_clr_generation", 64'(bus.generation), 64'd0);
    #2 clr = 1'b1;
    mgrid = '0; mgen = 0;
    look();
    chk("post_clr_halted", 64'(bus.halted), 64'd0);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    look();
    chk("post_clr_tick_ignored", 64'(bus.generation), 64'd0);
    write_cell(1, 1, 1'b1);
    write_cell(1, 2, 1'b1);
    write_cell(2, 1, 1'b1);
    do_step();
    repeat (3) cyc();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
